// File: rtl/apple_spawn_controller.sv
// rtl/apple_spawn_controller.sv - apple respawn sequencer with snake-body collision scan
//
// Purpose: on each game tick, detect the head landing on the apple, pulse body
// growth, draw an LFSR candidate and scan the body memory so the new apple
// never lands on the snake. After MAX_RETRY rejected draws the last candidate
// is committed anyway and Spawn_fail pulses.
//
// Ports:
//   Clk_50mhz, Rst          clock, synchronous active-high reset
//   Game_tick               one-cycle pulse per game step
//   Head_x, Head_y          snake head position
//   Body_len                body segments excluding the head
//   Seg_rd_en, Seg_rd_addr  body memory read request
//   Seg_x, Seg_y            body memory data, valid the cycle after the request
//   Apple_x, Apple_y        current apple position
//   Body_add_sig            one-cycle grow pulse per eat event
//   Busy                    respawn in progress
//   Spawn_fail              one-cycle pulse on a forced commit
module apple_spawn_controller #(
    parameter int          X_MAX     = 38,
    parameter int          Y_MAX     = 28,
    parameter logic [10:0] LFSR_SEED = 11'h5A5,
    parameter int          MAX_RETRY = 8,
    parameter int          DEF_X     = 28,
    parameter int          DEF_Y     = 13
) (
    input  logic       Clk_50mhz,
    input  logic       Rst,
    input  logic       Game_tick,
    input  logic [5:0] Head_x,
    input  logic [4:0] Head_y,
    input  logic [5:0] Body_len,
    output logic       Seg_rd_en,
    output logic [5:0] Seg_rd_addr,
    input  logic [5:0] Seg_x,
    input  logic [4:0] Seg_y,
    output logic [5:0] Apple_x,
    output logic [4:0] Apple_y,
    output logic       Body_add_sig,
    output logic       Busy,
    output logic       Spawn_fail
);

    typedef enum logic [2:0] {IDLE, DRAW, SCAN, CHECK, COMMIT} state_t;

    localparam logic [5:0] XM       = 6'(X_MAX);
    localparam logic [4:0] YM       = 5'(Y_MAX);
    localparam logic [7:0] RETRY_LM = 8'(MAX_RETRY - 1);

    state_t      state_q;
    logic [10:0] lfsr_q;
    logic [10:0] lfsr_d;
    logic [5:0]  cand_x_q;
    logic [4:0]  cand_y_q;
    logic [5:0]  len_q;
    logic [5:0]  apple_x_q;
    logic [4:0]  apple_y_q;
    logic [5:0]  rd_addr_q;
    logic [7:0]  retry_q;
    logic        rd_en_q;
    logic        first_q;
    logic        forced_q;
    logic        add_q;
    logic        fail_q;

    logic [5:0]  xr;
    logic [4:0]  yr;
    logic [5:0]  fold_x;
    logic [4:0]  fold_y;
    logic        seg_hit;
    logic        reject_c;

    // Fibonacci LFSR, x^11 + x^9 + 1
    assign lfsr_d = {lfsr_q[9:0], lfsr_q[10] ^ lfsr_q[8]};

    // Fold raw LFSR fields into the legal 1..MAX range
    assign xr     = lfsr_q[10:5];
    assign yr     = lfsr_q[4:0];
    assign fold_x = (xr == 6'd0) ? 6'd1 : ((xr > XM) ? xr - XM : xr);
    assign fold_y = (yr == 5'd0) ? 5'd1 : ((yr > YM) ? yr - YM : yr);

    assign seg_hit = (Seg_x == cand_x_q) && (Seg_y == cand_y_q);

    // First SCAN cycle has no read data yet, so its compare is suppressed
    always_comb begin
        reject_c = 1'b0;
        case (state_q)
            DRAW:    reject_c = (fold_x == Head_x) && (fold_y == Head_y);
            SCAN:    reject_c = !first_q && seg_hit;
            CHECK:   reject_c = seg_hit;
            default: reject_c = 1'b0;
        endcase
    end

    always_ff @(posedge Clk_50mhz) begin
        if (Rst) begin
            state_q   <= IDLE;
            lfsr_q    <= LFSR_SEED;
            cand_x_q  <= 6'(DEF_X);
            cand_y_q  <= 5'(DEF_Y);
            len_q     <= 6'd0;
            apple_x_q <= 6'(DEF_X);
            apple_y_q <= 5'(DEF_Y);
            rd_addr_q <= 6'd0;
            retry_q   <= 8'd0;
            rd_en_q   <= 1'b0;
            first_q   <= 1'b0;
            forced_q  <= 1'b0;
            add_q     <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            add_q  <= 1'b0;
            fail_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Game_tick && (apple_x_q == Head_x) && (apple_y_q == Head_y)) begin
                        add_q    <= 1'b1;
                        retry_q  <= 8'd0;
                        forced_q <= 1'b0;
                        state_q  <= DRAW;
                    end
                end
                DRAW: begin
                    cand_x_q <= fold_x;
                    cand_y_q <= fold_y;
                    len_q    <= Body_len;
                    if (Body_len == 6'd0) begin
                        state_q <= COMMIT;
                    end else begin
                        state_q   <= SCAN;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= 6'd0;
                        first_q   <= 1'b1;
                    end
                end
                SCAN: begin
                    first_q <= 1'b0;
                    if (rd_addr_q == len_q - 6'd1) begin
                        rd_en_q <= 1'b0;
                        state_q <= CHECK;
                    end else begin
                        rd_addr_q <= rd_addr_q + 6'd1;
                    end
                end
                CHECK: begin
                    state_q <= COMMIT;
                end
                COMMIT: begin
                    apple_x_q <= cand_x_q;
                    apple_y_q <= cand_y_q;
                    fail_q    <= forced_q;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // A reject overrides the normal transition and drops any outstanding reads
            if (reject_c) begin
                rd_en_q <= 1'b0;
                if (retry_q < RETRY_LM) begin
                    retry_q <= retry_q + 8'd1;
                    state_q <= DRAW;
                end else begin
                    forced_q <= 1'b1;
                    state_q  <= COMMIT;
                end
            end
        end
    end

    assign Seg_rd_en    = rd_en_q;
    assign Seg_rd_addr  = rd_addr_q;
    assign Apple_x      = apple_x_q;
    assign Apple_y      = apple_y_q;
    assign Body_add_sig = add_q;
    assign Busy         = (state_q != IDLE);
    assign Spawn_fail   = fail_q;

endmodule
